// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter sharing one memory request port between NUM_REQ requesters.
// Tags each issued request with a free transaction id and routes responses back by id.
module mem_req_arbiter #(
   parameter int NUM_REQ        = 3,
   parameter int ADDR_WIDTH     = 32,
   parameter int MEM_DATA_WIDTH = 64,
   parameter int NUM_TAGS       = 16,
   parameter int MAX_OUT        = 8,
   localparam int TW            = $clog2(NUM_TAGS)
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [NUM_REQ-1:0]                req_valid,
   output logic [NUM_REQ-1:0]                req_ready,
   input  logic [NUM_REQ*3-1:0]              req_cmd,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]     req_addr,
   input  logic [NUM_REQ*MEM_DATA_WIDTH-1:0] req_wdata,
   input  logic [NUM_REQ*8-1:0]              req_burst_len,
   output logic                              mem_req_valid,
   input  logic                              mem_req_ready,
   output logic [2:0]                        mem_cmd,
   output logic [ADDR_WIDTH-1:0]             mem_addr,
   output logic [MEM_DATA_WIDTH-1:0]         mem_wdata,
   output logic [7:0]                        mem_burst_len,
   output logic [TW-1:0]                     mem_id,
   input  logic                              mem_resp_valid,
   input  logic [TW-1:0]                     mem_resp_id,
   input  logic [MEM_DATA_WIDTH-1:0]         mem_resp_data,
   input  logic                              mem_resp_error,
   input  logic                              mem_resp_last,
   output logic [NUM_REQ-1:0]                resp_valid,
   output logic [MEM_DATA_WIDTH-1:0]         resp_data,
   output logic                              resp_error,
   output logic                              resp_last,
   output logic                              spurious_resp,
   output logic                              busy
);

   localparam int CW = $clog2(MAX_OUT) + 1;
   localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [2:0] {
      CMD_READ        = 3'd0,
      CMD_WRITE       = 3'd1,
      CMD_BURST_READ  = 3'd2,
      CMD_BURST_WRITE = 3'd3
   } mem_cmd_e;

   logic [NUM_TAGS-1:0]       tag_used_reg, tag_used_next;
   logic [OW-1:0]             tag_owner_reg [NUM_TAGS];
   logic [CW-1:0]             out_cnt_reg [NUM_REQ];
   logic [OW-1:0]             rr_ptr_reg;

   logic                      mem_req_valid_reg;
   mem_cmd_e                  mem_cmd_reg;
   logic [ADDR_WIDTH-1:0]     mem_addr_reg;
   logic [MEM_DATA_WIDTH-1:0] mem_wdata_reg;
   logic [7:0]                mem_burst_len_reg;
   logic [TW-1:0]             mem_id_reg;

   logic [NUM_REQ-1:0]        eligible;
   logic [NUM_REQ-1:0]        cnt_inc;
   logic [NUM_REQ-1:0]        cnt_dec;
   logic                      grant_found;
   logic [OW-1:0]             grant_idx;
   logic [OW:0]               search_idx;
   logic                      tag_found;
   logic [TW-1:0]             free_tag;
   logic                      slot_ok;
   logic                      accept;
   logic                      resp_hit;
   logic                      resp_free;
   logic [OW-1:0]             resp_owner;

   // Per-requester eligibility, handshake, counter deltas and response steering
   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
         assign eligible[gi]   = req_valid[gi] && (out_cnt_reg[gi] < CW'(MAX_OUT));
         assign req_ready[gi]  = accept && (grant_idx == OW'(gi));
         assign cnt_inc[gi]    = accept && (grant_idx == OW'(gi));
         assign cnt_dec[gi]    = resp_free && (resp_owner == OW'(gi));
         assign resp_valid[gi] = resp_hit && (resp_owner == OW'(gi));
      end
   endgenerate

   // Round-robin search starting at rr_ptr, wrapping at NUM_REQ
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      search_idx  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         search_idx = {1'b0, rr_ptr_reg} + (OW+1)'(k);
         if (search_idx >= (OW+1)'(NUM_REQ))
            search_idx = search_idx - (OW+1)'(NUM_REQ);
         if (!grant_found && eligible[search_idx[OW-1:0]]) begin
            grant_found = 1'b1;
            grant_idx   = search_idx[OW-1:0];
         end
      end
   end

   // Lowest-numbered free tag; only tags free at the start of the cycle count
   always_comb begin
      free_tag = '0;
      for (int t = NUM_TAGS - 1; t >= 0; t--) begin
         if (!tag_used_reg[t])
            free_tag = TW'(t);
      end
   end

   assign tag_found = ~&tag_used_reg;
   assign slot_ok   = tag_found && (!mem_req_valid_reg || mem_req_ready);
   assign accept    = !rst && slot_ok && grant_found;

   assign resp_owner    = tag_owner_reg[mem_resp_id];
   assign resp_hit      = !rst && mem_resp_valid && tag_used_reg[mem_resp_id];
   assign resp_free     = resp_hit && mem_resp_last;
   assign spurious_resp = !rst && mem_resp_valid && !tag_used_reg[mem_resp_id];
   assign resp_data     = resp_hit ? mem_resp_data : '0;
   assign resp_error    = resp_hit && mem_resp_error;
   assign resp_last     = resp_hit && mem_resp_last;

   always_comb begin
      tag_used_next = tag_used_reg;
      if (resp_free)
         tag_used_next[mem_resp_id] = 1'b0;
      if (accept)
         tag_used_next[free_tag] = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tag_used_reg <= '0;
         rr_ptr_reg   <= '0;
         for (int t = 0; t < NUM_TAGS; t++)
            tag_owner_reg[t] <= '0;
      end else begin
         tag_used_reg <= tag_used_next;
         if (accept) begin
            tag_owner_reg[free_tag] <= grant_idx;
            rr_ptr_reg <= ({1'b0, grant_idx} + 1'b1 >= (OW+1)'(NUM_REQ)) ?
                          '0 : grant_idx + 1'b1;
         end
      end
   end

   // Simultaneous accept and completion on one requester leaves its count unchanged
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_REQ; i++)
            out_cnt_reg[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (cnt_inc[i] && !cnt_dec[i])
               out_cnt_reg[i] <= out_cnt_reg[i] + 1'b1;
            else if (cnt_dec[i] && !cnt_inc[i])
               out_cnt_reg[i] <= out_cnt_reg[i] - 1'b1;
         end
      end
   end

   // Output register: fields only change on accept, so they hold under backpressure
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_req_valid_reg <= 1'b0;
         mem_cmd_reg       <= CMD_READ;
         mem_addr_reg      <= '0;
         mem_wdata_reg     <= '0;
         mem_burst_len_reg <= '0;
         mem_id_reg        <= '0;
      end else if (accept) begin
         mem_req_valid_reg <= 1'b1;
         mem_cmd_reg       <= mem_cmd_e'(req_cmd[grant_idx*3 +: 3]);
         mem_addr_reg      <= req_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
         mem_wdata_reg     <= req_wdata[grant_idx*MEM_DATA_WIDTH +: MEM_DATA_WIDTH];
         mem_burst_len_reg <= req_burst_len[grant_idx*8 +: 8];
         mem_id_reg        <= free_tag;
      end else if (mem_req_ready) begin
         mem_req_valid_reg <= 1'b0;
      end
   end

   assign mem_req_valid = mem_req_valid_reg;
   assign mem_cmd       = mem_cmd_reg;
   assign mem_addr      = mem_addr_reg;
   assign mem_wdata     = mem_wdata_reg;
   assign mem_burst_len = mem_burst_len_reg;
   assign mem_id        = mem_id_reg;
   assign busy          = (|tag_used_reg) | mem_req_valid_reg;

endmodule
